cpu_hazard_ctrl: RTL and testbench

Pipeline hazard and stall controller for the 5-stage 32-bit MIPS core. It produces the `hazard_detected` input consumed by `cpu_main_ctrl` and drives the PC and IF/ID write enables. It also drives the IF/ID, ID/EX and EX/MEM flush strobes. It sequences:
- multi-cycle load-use stalls
- taken-branch flushes
- jump bubbles
- decode-exception drains

---
 rtl/cpu_hazard_ctrl.sv | 142 ++++++++++++++
 tb/tb_cpu_hazard_ctrl.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/cpu_hazard_ctrl.sv
// Load-use stall, branch/jump flush and decode-exception drain sequencing for the 5-stage MIPS core.
// Optional performance counters are enabled by defining CPU_HAZARD_PERF_CNT_EN.
module cpu_hazard_ctrl #(
    parameter int LOAD_STALL_CYCLES = 1,
    parameter int EXC_DRAIN_CYCLES  = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] id_opcode,
    input  logic [4:0] id_rs,
    input  logic [4:0] id_rt,
    input  logic       ex_memread,
    input  logic [4:0] ex_rt,
    input  logic       id_jump,
    input  logic       id_decode_exc,
    input  logic       mem_branch_taken,
    output logic       hazard_detected,
    output logic       pc_write,
    output logic       ifid_write,
    output logic       flush_ifid,
    output logic       flush_idex,
    output logic       flush_exmem,
    output logic       exc_redirect
`ifdef CPU_HAZARD_PERF_CNT_EN
    ,
    output logic [31:0] stall_cycles,
    output logic [15:0] flush_events
`endif
);

    typedef enum logic [1:0] {RUN, LD_STALL, EXC_DRAIN} state_t;

    localparam int LD_INIT_I = (LOAD_STALL_CYCLES > 1) ? LOAD_STALL_CYCLES - 2 : 0;
    localparam logic [2:0] LD_INIT  = 3'(LD_INIT_I);
    localparam logic [2:0] EXC_INIT = 3'(EXC_DRAIN_CYCLES - 1);

    state_t     state, next_state;
    logic [2:0] cnt, next_cnt;
    logic       lu;

    function automatic logic reads_rt(input logic [5:0] opcode);
        case (opcode)
            6'b000000, 6'b101011, 6'b000100: reads_rt = 1'b1;
            default:                         reads_rt = 1'b0;
        endcase
    endfunction

    assign lu = ex_memread && (ex_rt != 5'd0) &&
                ((ex_rt == id_rs) || ((ex_rt == id_rt) && reads_rt(id_opcode)));

    always_comb begin
        next_state      = state;
        next_cnt        = cnt;
        hazard_detected = 1'b0;
        pc_write        = 1'b1;
        ifid_write      = 1'b1;
        flush_ifid      = 1'b0;
        flush_idex      = 1'b0;
        flush_exmem     = 1'b0;
        exc_redirect    = 1'b0;
        if (rst) begin
            hazard_detected = 1'b1;
            pc_write        = 1'b0;
            ifid_write      = 1'b0;
            next_state      = RUN;
            next_cnt        = 3'd0;
        end else if (mem_branch_taken) begin
            // A resolved taken branch wins over everything and aborts any sequence in flight.
            flush_ifid  = 1'b1;
            flush_idex  = 1'b1;
            flush_exmem = 1'b1;
            next_state  = RUN;
            next_cnt    = 3'd0;
        end else begin
            case (state)
                RUN: begin
                    if (id_decode_exc) begin
                        // Decoder stays enabled here so it can report the exception.
                        exc_redirect = 1'b1;
                        flush_ifid   = 1'b1;
                        flush_idex   = 1'b1;
                        next_state   = EXC_DRAIN;
                        next_cnt     = EXC_INIT;
                    end else if (lu) begin
                        hazard_detected = 1'b1;
                        pc_write        = 1'b0;
                        ifid_write      = 1'b0;
                        if (LOAD_STALL_CYCLES > 1) begin
                            next_state = LD_STALL;
                            next_cnt   = LD_INIT;
                        end
                    end else if (id_jump) begin
                        flush_ifid = 1'b1;
                    end
                end
                LD_STALL: begin
                    hazard_detected = 1'b1;
                    pc_write        = 1'b0;
                    ifid_write      = 1'b0;
                    if (cnt == 3'd0) next_state = RUN;
                    else             next_cnt   = cnt - 3'd1;
                end
                EXC_DRAIN: begin
                    hazard_detected = 1'b1;
                    flush_ifid      = 1'b1;
                    if (cnt == 3'd0) next_state = RUN;
                    else             next_cnt   = cnt - 3'd1;
                end
                default: begin
                    next_state = RUN;
                    next_cnt   = 3'd0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= RUN;
            cnt   <= 3'd0;
        end else begin
            state <= next_state;
            cnt   <= next_cnt;
        end
    end

`ifdef CPU_HAZARD_PERF_CNT_EN
    // Both counters saturate rather than wrap.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cycles <= 32'd0;
            flush_events <= 16'd0;
        end else begin
            if (hazard_detected && (stall_cycles != '1))
                stall_cycles <= stall_cycles + 32'd1;
            if ((flush_exmem || exc_redirect) && (flush_events != '1))
                flush_events <= flush_events + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_cpu_hazard_ctrl.sv
// Directed bench for cpu_hazard_ctrl: a default-parameter instance and a LOAD_STALL_CYCLES=3 instance share inputs.
module tb_cpu_hazard_ctrl;

    // Output vector order: {hazard, pc_write, ifid_write, flush_ifid, flush_idex, flush_exmem, exc_redirect}
    localparam logic [6:0] RST_O   = 7'b1000000;
    localparam logic [6:0] RUN_O   = 7'b0110000;
    localparam logic [6:0] STALL_O = 7'b1000000;
    localparam logic [6:0] BR_O    = 7'b0111110;
    localparam logic [6:0] EXC_O   = 7'b0111101;
    localparam logic [6:0] DRAIN_O = 7'b1111000;
    localparam logic [6:0] JUMP_O  = 7'b0111000;

    logic       clk = 1'b0;
    logic       rst;
    logic [5:0] id_opcode;
    logic [4:0] id_rs, id_rt, ex_rt;
    logic       ex_memread, id_jump, id_decode_exc, mem_branch_taken;
    logic [6:0] od, ol;
    logic [6:0] exp_o;
    int         vectors = 0;
    int         miscompares = 0;
`ifdef CPU_HAZARD_PERF_CNT_EN
    logic [31:0] d_stall, l_stall;
    logic [15:0] d_flush, l_flush;
`endif

    always #5 clk = ~clk;

    cpu_hazard_ctrl u_d (
        .clk(clk), .rst(rst), .id_opcode(id_opcode), .id_rs(id_rs), .id_rt(id_rt),
        .ex_memread(ex_memread), .ex_rt(ex_rt), .id_jump(id_jump),
        .id_decode_exc(id_decode_exc), .mem_branch_taken(mem_branch_taken),
        .hazard_detected(od[6]), .pc_write(od[5]), .ifid_write(od[4]), .flush_ifid(od[3]),
        .flush_idex(od[2]), .flush_exmem(od[1]), .exc_redirect(od[0])
`ifdef CPU_HAZARD_PERF_CNT_EN
        , .stall_cycles(d_stall), .flush_events(d_flush)
`endif
    );

    cpu_hazard_ctrl #(.LOAD_STALL_CYCLES(3)) u_l3 (
        .clk(clk), .rst(rst), .id_opcode(id_opcode), .id_rs(id_rs), .id_rt(id_rt),
        .ex_memread(ex_memread), .ex_rt(ex_rt), .id_jump(id_jump),
        .id_decode_exc(id_decode_exc), .mem_branch_taken(mem_branch_taken),
        .hazard_detected(ol[6]), .pc_write(ol[5]), .ifid_write(ol[4]), .flush_ifid(ol[3]),
        .flush_idex(ol[2]), .flush_exmem(ol[1]), .exc_redirect(ol[0])
`ifdef CPU_HAZARD_PERF_CNT_EN
        , .stall_cycles(l_stall), .flush_events(l_flush)
`endif
    );

    task automatic idle_inputs();
        id_opcode = 6'b000000; id_rs = 5'd0; id_rt = 5'd0; ex_rt = 5'd0;
        ex_memread = 1'b0; id_jump = 1'b0; id_decode_exc = 1'b0; mem_branch_taken = 1'b0;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        idle_inputs();
        rst = 1'b1;
        next_cycle();
        next_cycle();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1'b1;
        ex_memread = 1'b1; id_decode_exc = 1'b1; mem_branch_taken = 1'b1;
        @(negedge clk); vectors++;
        if (od !== RST_O) begin miscompares++; $display("FAIL reset_out_d: got %b want %b", od, RST_O); end
        vectors++;
        if (ol !== RST_O) begin miscompares++; $display("FAIL reset_out_l3: got %b want %b", ol, RST_O); end
        next_cycle();
        idle_inputs();
        rst = 1'b0;
        @(negedge clk); vectors++;
        if (od !== RUN_O) begin miscompares++; $display("FAIL first_run_after_reset: got %b want %b", od, RUN_O); end
`ifdef CPU_HAZARD_PERF_CNT_EN
        vectors++;
        if (d_stall !== 32'd0 || d_flush !== 16'd0) begin
            miscompares++; $display("FAIL reset_counters: got %0d/%0d want 0/0", d_stall, d_flush);
        end
`endif
    endtask

    task automatic test_load_use();
        apply_reset();
        ex_memread = 1'b1; ex_rt = 5'd5; id_opcode = 6'b000000; id_rt = 5'd5; id_rs = 5'd1;
        @(negedge clk); vectors++;
        if (od !== STALL_O) begin miscompares++; $display("FAIL lu_rtype_rt: got %b want %b", od, STALL_O); end
        next_cycle();
        ex_memread = 1'b0;
        @(negedge clk); vectors++;
        if (od !== RUN_O) begin miscompares++; $display("FAIL lu_resume: got %b want %b", od, RUN_O); end
        // lw in ID reads only rs: an rt match must not stall, an rs match must.
        next_cycle();
        ex_memread = 1'b1; ex_rt = 5'd7; id_opcode = 6'b100011; id_rs = 5'd3; id_rt = 5'd7;
        @(negedge clk); vectors++;
        if (od !== RUN_O) begin miscompares++; $display("FAIL lu_lw_rt_ignored: got %b want %b", od, RUN_O); end
        id_rs = 5'd7; id_rt = 5'd2;
        @(negedge clk); #1; vectors++;
        if (od !== STALL_O) begin miscompares++; $display("FAIL lu_lw_rs: got %b want %b", od, STALL_O); end
        next_cycle();
        ex_rt = 5'd9; id_opcode = 6'b000100; id_rs = 5'd1; id_rt = 5'd9;
        @(negedge clk); vectors++;
        if (od !== STALL_O) begin miscompares++; $display("FAIL lu_beq_rt: got %b want %b", od, STALL_O); end
        ex_memread = 1'b0;
        @(negedge clk); #1; vectors++;
        if (od !== RUN_O) begin miscompares++; $display("FAIL lu_no_memread: got %b want %b", od, RUN_O); end
    endtask

    task automatic test_ld_stall3();
        apply_reset();
        ex_memread = 1'b1; ex_rt = 5'd8; id_opcode = 6'b101011; id_rs = 5'd2; id_rt = 5'd8;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); vectors++;
            exp_o = (i < 3) ? STALL_O : RUN_O;
            if (ol !== exp_o) begin miscompares++; $display("FAIL ld3_cycle%0d: got %b want %b", i, ol, exp_o); end
            next_cycle();
            ex_memread = 1'b0;
        end
        ex_memread = 1'b1; ex_rt = 5'd0; id_rs = 5'd0; id_rt = 5'd0;
        @(negedge clk); vectors++;
        if (ol !== RUN_O) begin miscompares++; $display("FAIL ld3_r0_no_stall: got %b want %b", ol, RUN_O); end
    endtask

    task automatic test_decode_exc();
        apply_reset();
        id_opcode = 6'b001111; id_decode_exc = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (i == 3) id_decode_exc = 1'b0;
            @(negedge clk); vectors++;
            exp_o = (i == 0) ? EXC_O : ((i < 3) ? DRAIN_O : RUN_O);
            if (od !== exp_o) begin miscompares++; $display("FAIL exc_cycle%0d: got %b want %b", i, od, exp_o); end
            next_cycle();
        end
    endtask

    task automatic test_branch_abort();
        apply_reset();
        ex_memread = 1'b1; ex_rt = 5'd4; id_opcode = 6'b000000; id_rs = 5'd4;
        @(negedge clk); vectors++;
        if (ol !== STALL_O) begin miscompares++; $display("FAIL br_pre_stall: got %b want %b", ol, STALL_O); end
        next_cycle();
        ex_memread = 1'b0; mem_branch_taken = 1'b1; id_decode_exc = 1'b1;
        @(negedge clk); vectors++;
        if (ol !== BR_O) begin miscompares++; $display("FAIL br_in_ld_stall: got %b want %b", ol, BR_O); end
        next_cycle();
        idle_inputs();
        @(negedge clk); vectors++;
        if (ol !== RUN_O) begin miscompares++; $display("FAIL br_then_run: got %b want %b", ol, RUN_O); end
        mem_branch_taken = 1'b1; id_jump = 1'b1;
        @(negedge clk); #1; vectors++;
        if (od !== BR_O) begin miscompares++; $display("FAIL br_over_jump: got %b want %b", od, BR_O); end
    endtask

    task automatic test_jump();
        apply_reset();
        id_jump = 1'b1; id_opcode = 6'b000010;
        @(negedge clk); vectors++;
        if (od !== JUMP_O) begin miscompares++; $display("FAIL jump_run: got %b want %b", od, JUMP_O); end
        ex_memread = 1'b1; ex_rt = 5'd3; id_rs = 5'd3;
        @(negedge clk); #1; vectors++;
        if (od !== STALL_O) begin miscompares++; $display("FAIL lu_over_jump: got %b want %b", od, STALL_O); end
        next_cycle();
        idle_inputs();
        @(negedge clk); vectors++;
        if (od !== RUN_O) begin miscompares++; $display("FAIL jump_after: got %b want %b", od, RUN_O); end
    endtask

    task automatic test_rst_in_drain();
        apply_reset();
        id_decode_exc = 1'b1;
        next_cycle();
        id_decode_exc = 1'b0;
        @(negedge clk); vectors++;
        if (od !== DRAIN_O) begin miscompares++; $display("FAIL drain_before_rst: got %b want %b", od, DRAIN_O); end
`ifdef CPU_HAZARD_PERF_CNT_EN
        vectors++;
        if (d_flush !== 16'd1) begin miscompares++; $display("FAIL flush_events_count: got %0d want 1", d_flush); end
`endif
        rst = 1'b1;
        @(negedge clk); #1; vectors++;
        if (od !== RST_O) begin miscompares++; $display("FAIL rst_in_drain: got %b want %b", od, RST_O); end
        next_cycle();
        rst = 1'b0;
        @(negedge clk); vectors++;
        if (od !== RUN_O) begin miscompares++; $display("FAIL run_after_drain_rst: got %b want %b", od, RUN_O); end
`ifdef CPU_HAZARD_PERF_CNT_EN
        vectors++;
        if (d_stall !== 32'd0 || d_flush !== 16'd0) begin
            miscompares++; $display("FAIL counters_after_rst: got %0d/%0d want 0/0", d_stall, d_flush);
        end
`endif
    endtask

    initial begin
        idle_inputs();
        rst = 1'b1;
        test_reset();
        test_load_use();
        test_ld_stall3();
        test_decode_exc();
        test_branch_abort();
        test_jump();
        test_rst_in_drain();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
